match_window_counter: RTL and testbench

Downstream consumer of the 1100 Mealy sequence detector's `z1` match output. Counts detected matches over fixed-length windows of clock cycles and hands each window's total to a downstream reader over a valid/ready handshake. Flags windows whose count reaches a threshold, and records results dropped under backpressure. Sits between the detector and any status/readout logic.

---
 rtl/match_window_counter_if.sv | 27 ++
 rtl/match_window_counter.sv | 111 +++++++++++
 tb/tb_match_window_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/match_window_counter_if.sv
// Result bus between the window counter and its downstream reader.
interface match_window_counter_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;
  logic             alarm;
  logic             overflow;

  // Counter side drives the result, reader side drives ready.
  modport master (
    output count_out,
    output count_valid,
    output alarm,
    output overflow,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_valid,
    input  alarm,
    input  overflow,
    output count_ready
  );
endinterface

// File: rtl/match_window_counter.sv
// Counts detector matches over fixed windows of enabled cycles and offers each
// window total to a reader over valid/ready, with a threshold alarm and a
// sticky flag for results dropped under backpressure.
module match_window_counter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned THRESH  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   z1,
  match_window_counter_if.master rd
);

  localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e           state_c;
  logic [CNT_W:0]   sum_c;
  logic [CNT_W-1:0] final_c;
  logic             close_c;

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0] out_q,     out_d;
  logic             alarm_q,   alarm_d;
  logic             valid_q,   valid_d;
  logic             ovf_q,     ovf_d;

  // Operating mode follows enable directly each cycle; there is no stored state.
  always_comb begin
    state_c = enable ? RUN : PAUSE;
  end

  // Saturating accumulate of this edge's z1 into the running window total.
  always_comb begin
    sum_c   = {1'b0, acc_q} + (CNT_W+1)'(z1);
    final_c = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
  end

  // Window timer, accumulator and result-register next-state.
  always_comb begin
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    out_d     = out_q;
    alarm_d   = alarm_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    close_c   = 1'b0;

    case (state_c)
      RUN: begin
        if (win_cnt_q == WIN_LAST) begin
          close_c   = 1'b1;
          win_cnt_d = '0;
          acc_d     = '0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          acc_d     = final_c;
        end
      end
      default: begin
      end
    endcase

    if (close_c) begin
      // A held, unaccepted result wins; the new total is dropped and flagged.
      if (!valid_q || rd.count_ready) begin
        out_d   = final_c;
        alarm_d = (32'(final_c) >= THRESH);
        valid_d = 1'b1;
      end else begin
        ovf_d   = 1'b1;
      end
    end else if (valid_q && rd.count_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      alarm_q   <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      alarm_q   <= alarm_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rd.count_out   = out_q;
  assign rd.count_valid = valid_q;
  assign rd.alarm       = alarm_q;
  assign rd.overflow    = ovf_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter: two instances (8-bit and 3-bit count) share
// one stimulus stream and are compared each cycle against a window model.
module tb_match_window_counter;

  localparam int unsigned WIN_LEN = 16;
  localparam int unsigned THRESH  = 3;

  logic clk;
  logic reset;
  logic enable;
  logic z1;
  logic rdy;

  int checks;
  int errors;

  match_window_counter_if #(.CNT_W(8)) if8 ();
  match_window_counter_if #(.CNT_W(3)) if3 ();

  assign if8.count_ready = rdy;
  assign if3.count_ready = rdy;

  match_window_counter #(.CNT_W(8), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut8 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .z1     (z1),
    .rd     (if8)
  );

  match_window_counter #(.CNT_W(3), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .z1     (z1),
    .rd     (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: counts enabled edges and matches with plain integers; a result is
  // min(matches, max) once WIN_LEN enabled edges have elapsed.
  int m_max   [2] = '{255, 7};
  int m_edges [2];
  int m_match [2];
  int m_out   [2];
  bit m_valid [2];
  bit m_alarm [2];
  bit m_ovf   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_edges[k] = 0;
        m_match[k] = 0;
        m_out[k]   = 0;
        m_valid[k] = 1'b0;
        m_alarm[k] = 1'b0;
        m_ovf[k]   = 1'b0;
      end else begin
        bit closed;
        int res;
        closed = 1'b0;
        res    = 0;
        if (enable) begin
          m_match[k] += (z1 === 1'b1) ? 1 : 0;
          m_edges[k] += 1;
          if (m_edges[k] == WIN_LEN) begin
            closed     = 1'b1;
            res        = (m_match[k] > m_max[k]) ? m_max[k] : m_match[k];
            m_edges[k] = 0;
            m_match[k] = 0;
          end
        end
        if (closed) begin
          if (!m_valid[k] || rdy) begin
            m_out[k]   = res;
            m_alarm[k] = (res >= THRESH);
            m_valid[k] = 1'b1;
          end else begin
            m_ovf[k] = 1'b1;
          end
        end else if (m_valid[k] && rdy) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] d_out   [2];
    logic       d_valid [2];
    logic       d_alarm [2];
    logic       d_ovf   [2];
    d_out[0]   = if8.count_out;
    d_out[1]   = {5'd0, if3.count_out};
    d_valid[0] = if8.count_valid;
    d_valid[1] = if3.count_valid;
    d_alarm[0] = if8.alarm;
    d_alarm[1] = if3.alarm;
    d_ovf[0]   = if8.overflow;
    d_ovf[1]   = if3.overflow;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_valid[k] !== m_valid[k] || d_ovf[k] !== m_ovf[k]) begin
        errors++;
        $display("FAIL model_flags[%0d] t=%0t: valid=%b ovf=%b expected valid=%b ovf=%b",
                 k, $time, d_valid[k], d_ovf[k], m_valid[k], m_ovf[k]);
      end
      if (m_valid[k]) begin
        checks++;
        if (d_out[k] !== 8'(m_out[k]) || d_alarm[k] !== m_alarm[k]) begin
          errors++;
          $display("FAIL model_result[%0d] t=%0t: count=%0d alarm=%b expected count=%0d alarm=%b",
                   k, $time, d_out[k], d_alarm[k], m_out[k], m_alarm[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs set at negedge, z1 glitched between edges, back at negedge.
  task automatic step(input logic en, input logic zz, input logic rd_i, input logic rst);
    enable = en;
    z1     = zz;
    rdy    = rd_i;
    reset  = rst;
    @(posedge clk);
    #1 z1 = ~zz;
    #2 z1 = zz;
    @(negedge clk);
  endtask

  task automatic run_window(input logic [15:0] zpat, input logic [15:0] rmask);
    for (int i = 0; i < 16; i++) step(1'b1, zpat[i], rmask[i], 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    enable = 1'b1;
    z1     = 1'b1;
    rdy    = 1'b1;
    @(negedge clk);

    // Reset held two cycles with z1 active.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_valid", 8'(if8.count_valid), 8'd0);
    chk("reset_count", if8.count_out, 8'd0);
    chk("reset_alarm", 8'(if8.alarm), 8'd0);
    chk("reset_ovf",   8'(if8.overflow), 8'd0);

    // Detector stream: one pulse every four cycles.
    run_window(16'h8888, 16'hFFFF);
    chk("win1_valid", 8'(if8.count_valid), 8'd1);
    chk("win1_count", if8.count_out, 8'd4);
    chk("win1_alarm", 8'(if8.alarm), 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("win1_accepted", 8'(if8.count_valid), 8'd0);
    run_window(16'h8888, 16'hFFFF);
    chk("win2_count", if8.count_out, 8'd4);
    run_window(16'h0808, 16'hFFFF);
    chk("win3_count", if8.count_out, 8'd2);
    chk("win3_alarm", 8'(if8.alarm), 8'd0);
    chk("win3_valid", 8'(if8.count_valid), 8'd1);

    // Saturation of the narrow instance.
    run_window(16'hFFFF, 16'hFFFF);
    chk("sat_count8", if8.count_out, 8'd16);
    chk("sat_count3", {5'd0, if3.count_out}, 8'd7);
    chk("sat_alarm3", 8'(if3.alarm), 8'd1);

    // Backpressure across two closes.
    run_window(16'h8888, 16'h0001);
    chk("bp_a_count", if8.count_out, 8'd4);
    chk("bp_a_ovf",   8'(if8.overflow), 8'd0);
    run_window(16'h0100, 16'h0000);
    chk("bp_b_count", if8.count_out, 8'd4);
    chk("bp_b_valid", 8'(if8.count_valid), 8'd1);
    chk("bp_b_ovf",   8'(if8.overflow), 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_drain_valid", 8'(if8.count_valid), 8'd0);
    chk("bp_drain_ovf",   8'(if8.overflow), 8'd1);

    // Accept on the close edge of the next window.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst2_ovf", 8'(if8.overflow), 8'd0);
    run_window(16'h0421, 16'hFFFF);
    chk("close_c_count", if8.count_out, 8'd3);
    run_window(16'h0808, 16'h8000);
    chk("close_d_count", if8.count_out, 8'd2);
    chk("close_d_valid", 8'(if8.count_valid), 8'd1);
    chk("close_d_ovf",   8'(if8.overflow), 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Pause for five cycles with z1 high: not counted, close delayed.
    for (int i = 0; i < 8; i++) step(1'b1, (i == 3), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, (i == 5), 1'b1, 1'b0);
    chk("pause_not_closed", 8'(if8.count_valid), 8'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pause_count", if8.count_out, 8'd2);
    chk("pause_valid", 8'(if8.count_valid), 8'd1);

    // Reset at win_cnt=9 discards the partial window.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_valid", 8'(if8.count_valid), 8'd0);
    begin
      logic [15:0] pat;
      pat = 16'h1113;
      for (int i = 0; i < 15; i++) step(1'b1, pat[i], 1'b1, 1'b0);
      chk("midrst_not_closed", 8'(if8.count_valid), 8'd0);
      step(1'b1, pat[15], 1'b1, 1'b0);
    end
    chk("midrst_count", if8.count_out, 8'd5);
    chk("midrst_alarm", 8'(if8.alarm), 8'd1);
    chk("midrst_valid2", 8'(if8.count_valid), 8'd1);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
